// File: rtl/vdecoder.sv
// vdecoder: hard-decision register-exchange Viterbi decoder for the rate-1/2 K=3 code (g0=1+D, g1=1+D+D^2)
module vdecoder #(
  parameter int TB   = 8,
  parameter int PM_W = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  input  logic in_valid,
  output logic out,
  output logic out_valid
);
  localparam int CW = $clog2(TB + 1);
  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'((1 << (PM_W - 1)) - 1);
  logic            phase_q, phase_d, r0_q, r0_d, pend_q, pend_d;
  logic            out_q, out_d, out_valid_q, out_valid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PM_W-1:0] pm_q [4];
  logic [PM_W-1:0] pm_d [4];
  logic [TB-1:0]   path_q [4];
  logic [TB-1:0]   path_d [4];
  logic [PM_W:0]   nm [4];
  logic [PM_W:0]   nrm [4];
  logic            sel [4];
  logic [PM_W:0]   mn;
  logic [1:0]      best;
  logic            acs;
  assign acs = in_valid & phase_q;
  function automatic logic [PM_W:0] bm(input logic a, input logic b, input logic e0, input logic e1);
    return (PM_W+1)'(a ^ e0) + (PM_W+1)'(b ^ e1);
  endfunction
  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam logic N1 = n[1];
    localparam logic N0 = n[0];
    logic [PM_W:0] c0, c1;
    assign c0     = {1'b0, pm_q[{N0, 1'b0}]} + bm(r0_q, in, N1 ^ N0, N1 ^ N0);
    assign c1     = {1'b0, pm_q[{N0, 1'b1}]} + bm(r0_q, in, N1 ^ N0, ~(N1 ^ N0));
    assign sel[n] = c1 < c0;
    assign nm[n]  = sel[n] ? c1 : c0;
    assign nrm[n] = nm[n] - mn;
  end
  // smallest candidate metric, subtracted from all four to keep min pm at zero
  always_comb begin
    logic [PM_W:0] m01, m23;
    m01 = nm[1] < nm[0] ? nm[1] : nm[0];
    m23 = nm[3] < nm[2] ? nm[3] : nm[2];
    mn  = m23 < m01 ? m23 : m01;
  end
  // best state on registered metrics, ties go to the lowest index
  always_comb begin
    logic [1:0] b01, b23;
    b01  = pm_q[1] < pm_q[0] ? 2'd1 : 2'd0;
    b23  = pm_q[3] < pm_q[2] ? 2'd3 : 2'd2;
    best = pm_q[b23] < pm_q[b01] ? b23 : b01;
  end
  // pairing, add-compare-select, normalisation and output staging
  always_comb begin
    phase_d     = in_valid ? ~phase_q : phase_q;
    r0_d        = in_valid && !phase_q ? in : r0_q;
    cnt_d       = acs && cnt_q != CW'(TB) ? cnt_q + 1'b1 : cnt_q;
    pend_d      = acs && cnt_d == CW'(TB);
    out_d       = pend_q ? path_q[best][TB-1] : out_q;
    out_valid_d = pend_q;
    for (int n = 0; n < 4; n++) begin
      pm_d[n]   = !acs ? pm_q[n] : nrm[n] > {1'b0, PM_MAX} ? PM_MAX : nrm[n][PM_W-1:0];
      path_d[n] = acs ? {path_q[{n[0], sel[n]}][TB-2:0], n[1]} : path_q[n];
    end
  end
  // state registers with asynchronous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q     <= 1'b0;
      r0_q        <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= i == 0 ? '0 : PM_INIT;
        path_q[i] <= '0;
      end
    end else begin
      phase_q     <= phase_d;
      r0_q        <= r0_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        path_q[i] <= path_d[i];
      end
    end
  end
  assign out       = out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_vdecoder.sv
// tb_vdecoder: directed-vector bench for the K=3 Viterbi decoder
module tb_vdecoder;
  localparam int TB = 8;
  localparam int PMAX = 63;
  localparam int PINIT = 31;
  logic clock = 0, reset = 0, in = 0, in_valid = 0;
  logic out, out_valid;
  int   errors = 0, checks = 0, cyc = 0;
  bit   gotq[$];
  int   gotc[$], acsc[$];
  bit   expq[$];
  int   mpm[4];
  bit   dech[0:1023][0:3];
  int   nst;
  bit   clean[$] = '{1,1, 1,1, 1,0, 0,0, 1,0, 0,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0};
  bit   hand[$]  = '{1,0,1,1,0,0,0,0,0};
  vdecoder #(.TB(TB), .PM_W(6)) dut (
    .clock(clock), .reset(reset), .in(in), .in_valid(in_valid), .out(out), .out_valid(out_valid)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (out_valid) begin
    gotq.push_back(out);
    gotc.push_back(cyc);
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void mstep(bit r0, bit r1);
    int nw[4];
    int mn, best, s;
    for (int n = 0; n < 4; n++) begin
      int n1, n0;
      int c[2];
      n1 = n / 2;
      n0 = n % 2;
      for (int x = 0; x < 2; x++) c[x] = mpm[n0*2+x] + (r0 ^ (n1 ^ n0)) + (r1 ^ (n1 ^ n0 ^ x));
      dech[nst][n] = c[1] < c[0];
      nw[n] = c[1] < c[0] ? c[1] : c[0];
    end
    mn = nw[0];
    for (int n = 1; n < 4; n++) if (nw[n] < mn) mn = nw[n];
    for (int n = 0; n < 4; n++) mpm[n] = nw[n] - mn > PMAX ? PMAX : nw[n] - mn;
    nst++;
    if (nst >= TB) begin
      best = 0;
      for (int n = 1; n < 4; n++) if (mpm[n] < mpm[best]) best = n;
      s = best;
      for (int d = 0; d < TB - 1; d++) s = (s % 2) * 2 + int'(dech[nst-1-d][s]);
      expq.push_back(s / 2);
    end
  endfunction
  task automatic drive(input bit b);
    @(negedge clock);
    in = b;
    in_valid = 1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 0;
    end
  endtask
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 0;
    in_valid = 0;
    #1 chk({tag, "_ov_async"}, out_valid, 0);
    repeat (2) begin
      @(negedge clock);
      chk({tag, "_ov_in_rst"}, out_valid, 0);
    end
    gotq.delete(); gotc.delete(); acsc.delete(); expq.delete();
    mpm = '{0, PINIT, PINIT, PINIT};
    nst = 0;
    reset = 1;
  endtask
  task automatic send(input bit c[$], input int npairs, input int gin, input int gmax);
    for (int p = 0; p < npairs; p++) begin
      drive(c[2*p]);
      if (gin > 0) idle(gin);
      drive(c[2*p+1]);
      acsc.push_back(cyc + 1);
      mstep(c[2*p], c[2*p+1]);
      if (gmax > 0) idle($urandom_range(0, gmax));
    end
    idle(6);
  endtask
  task automatic compare(input string tag, input bit exp[$]);
    chk({tag, "_count"}, gotq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < gotq.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), gotq[i], exp[i]);
  endtask
  initial begin
    bit err[$], zq[$], zexp[$], alt[$];
    do_reset("rst0");
    chk("rst_out", out, 0);
    chk("rst_pm0", dut.pm_q[0], 0);
    chk("rst_pm1", dut.pm_q[1], PINIT);
    chk("rst_pm3", dut.pm_q[3], PINIT);
    send(clean, 16, 0, 0);
    compare("clean", hand);
    if (gotc.size() > 0 && acsc.size() >= TB) chk("clean_latency", gotc[0], acsc[TB-1] + 1);
    else chk("clean_latency_seen", gotc.size(), 1);
    do_reset("rst1");
    err = clean;
    err[5] = 1;
    send(err, 16, 0, 0);
    compare("single_err", hand);
    do_reset("rst2");
    send(clean, 16, 3, 4);
    compare("gapped", hand);
    do_reset("rst3");
    send(clean, 5, 0, 0);
    drive(clean[10]);
    do_reset("midpair");
    send(clean, 16, 0, 0);
    compare("after_rst", hand);
    do_reset("rst4");
    for (int i = 0; i < 400; i++) zq.push_back(0);
    for (int i = 0; i < 200 - TB + 1; i++) zexp.push_back(0);
    send(zq, 200, 0, 0);
    compare("zeros", zexp);
    chk("zeros_pm0", dut.pm_q[0], 0);
    do_reset("rst5");
    for (int i = 0; i < 20; i++) begin
      alt.push_back(i % 2);
      alt.push_back(1 - i % 2);
    end
    send(alt, 20, 0, 1);
    compare("tiebreak", expq);
    for (int n = 0; n < 4; n++) chk($sformatf("tiebreak_pm%0d", n), dut.pm_q[n], mpm[n]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
